// File: rtl/load_store_unit.sv
// RV32I load/store unit between the multicycle control path and the data RAM controller.
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int ADDR_W     = 10,
  parameter int WRITE_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic              misalign,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, RD_WAIT, WR_WAIT, FAULT} state_t;

  localparam int CNT_W = (WRITE_WAIT > 1) ? $clog2(WRITE_WAIT) : 1;

  state_t state, state_n;

  logic              is_store_q, is_store_n;
  logic [2:0]        f3_q, f3_n;
  logic [1:0]        off_q, off_n;
  logic [CNT_W-1:0]  wcnt_q, wcnt_n;
  logic              done_n, mem_read_n, mem_write_n;
  logic [31:0]       rdata_n, wdata_n;
  logic [3:0]        be_n;
  logic [ADDR_W-1:0] maddr_n;

  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_fault;
  logic [31:0] sh;
  logic [31:0] ext;

  // Upper address bits and the high part of the shifted read word are not needed.
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[31:ADDR_W+2], sh[31:16]};

  assign busy = (state != IDLE);

  // Request decode: halfword/word offsets are forced aligned; trapping flags them instead.
  always_comb begin
    req_off   = addr[1:0];
    req_be    = 4'b1111;
    req_wdata = wdata_in;
    req_fault = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        req_off   = {addr[1], 1'b0};
        req_be    = 4'b0011 << {addr[1], 1'b0};
        req_wdata = {2{wdata_in[15:0]}};
      end
      default: req_off = 2'b00;
    endcase
`ifdef MISALIGN_TRAP_EN
    req_fault = ((funct3[1:0] == 2'b01) && addr[0]) ||
                (funct3[1] && (addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    sh = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; pulse outputs default low and are produced one edge early so they register.
  always_comb begin
    state_n     = state;
    is_store_n  = is_store_q;
    f3_n        = f3_q;
    off_n       = off_q;
    wcnt_n      = wcnt_q;
    done_n      = 1'b0;
    mem_read_n  = 1'b0;
    mem_write_n = 1'b0;
    rdata_n     = rdata_out;
    wdata_n     = mem_wdata;
    be_n        = mem_byteena;
    maddr_n     = mem_addr;
    case (state)
      IDLE: begin
        if (start) begin
          is_store_n = is_store;
          f3_n       = funct3;
          off_n      = req_off;
          be_n       = req_be;
          wdata_n    = req_wdata;
          maddr_n    = addr[ADDR_W+1:2];
          if (req_fault) begin
            state_n = FAULT;
            done_n  = 1'b1;
          end else begin
            state_n     = REQ;
            mem_read_n  = ~is_store;
            mem_write_n = is_store;
          end
        end
      end
      REQ: begin
        wcnt_n  = '0;
        state_n = is_store_q ? WR_WAIT : RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_valid) begin
          rdata_n = ext;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      WR_WAIT: begin
        if (wcnt_q == CNT_W'(WRITE_WAIT - 1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt_q + 1'b1;
        end
      end
      FAULT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      is_store_q  <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      wcnt_q      <= '0;
      done        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      rdata_out   <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_byteena <= 4'd0;
      mem_addr    <= '0;
    end else begin
      is_store_q  <= is_store_n;
      f3_q        <= f3_n;
      off_q       <= off_n;
      wcnt_q      <= wcnt_n;
      done        <= done_n;
      mem_read    <= mem_read_n;
      mem_write   <= mem_write_n;
      rdata_out   <= rdata_n;
      mem_wdata   <= wdata_n;
      mem_byteena <= be_n;
      mem_addr    <= maddr_n;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= (state == IDLE) && start && req_fault;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a hand-driven RAM response.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        busy, done, misalign, mem_read, mem_write;
  logic [31:0] rdata_out;
  logic [3:0]  mem_byteena;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  localparam int WRITE_WAIT = 1;

  load_store_unit #(.ADDR_W(10), .WRITE_WAIT(WRITE_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata_in(wdata_in), .busy(busy), .done(done), .rdata_out(rdata_out),
    .misalign(misalign), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteena(mem_byteena), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns just after the edge that accepted it.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata_in = wd;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
    wdata_in = 32'd0; mem_valid = 1'b0; mem_rdata = 32'd0;
    step(); step();
    checks++;
    if ({busy, done, misalign, mem_read, mem_write} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {busy, done, misalign, mem_read, mem_write});
    end
    checks++;
    if ({rdata_out, mem_wdata, mem_byteena, mem_addr} !== 78'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %b %h expected zeros",
               rdata_out, mem_wdata, mem_byteena, mem_addr);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_sw();
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++;
    if ({busy, mem_read, mem_write, mem_byteena, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b1, 4'b1111, 10'd4, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL sw_req: got busy=%b rd=%b wr=%b be=%b a=%h d=%h expected 1 0 1 1111 004 deadbeef",
               busy, mem_read, mem_write, mem_byteena, mem_addr, mem_wdata);
    end
    for (int i = 0; i < WRITE_WAIT; i++) begin
      step();
      checks++;
      if ({mem_write, done} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL sw_wait: got wr=%b done=%b expected 0 0", mem_write, done);
      end
    end
    step();
    checks++;
    if ({done, busy, misalign} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL sw_done: got done/busy/mis=%b expected 100", {done, busy, misalign});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_done_pulse: got %b expected 0", done);
    end
  endtask

  // Runs a load through REQ and a one-cycle RAM response, checking request fields and result.
  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] ram, input logic [3:0] exp_be,
                          input logic [9:0] exp_addr, input logic [31:0] exp_data);
    issue(1'b0, f3, a, 32'h0);
    checks++;
    if ({mem_read, mem_write, mem_byteena, mem_addr} !== {1'b1, 1'b0, exp_be, exp_addr}) begin
      errors++;
      $display("[TB] FAIL %s_req: got rd=%b wr=%b be=%b a=%h expected 1 0 %b %h",
               name, mem_read, mem_write, mem_byteena, mem_addr, exp_be, exp_addr);
    end
    step();
    mem_valid = 1'b1; mem_rdata = ram;
    step();
    mem_valid = 1'b0; mem_rdata = 32'h0;
    checks++;
    if ({done, rdata_out} !== {1'b1, exp_data}) begin
      errors++;
      $display("[TB] FAIL %s_data: got done=%b data=%h expected 1 %h", name, done, rdata_out, exp_data);
    end
    step();
  endtask

  task automatic test_lb_lbu();
    run_load("lb", 3'b000, 32'h13, 32'h80000000, 4'b1000, 10'd4, 32'hFFFFFF80);
    run_load("lbu", 3'b100, 32'h13, 32'h80000000, 4'b1000, 10'd4, 32'h00000080);
  endtask

  task automatic test_lh_lhu();
    run_load("lh", 3'b001, 32'h02, 32'h80010000, 4'b1100, 10'd0, 32'hFFFF8001);
    run_load("lhu", 3'b101, 32'h02, 32'h80010000, 4'b1100, 10'd0, 32'h00008001);
    run_load("lw11", 3'b011, 32'h08, 32'h89ABCDEF, 4'b1111, 10'd2, 32'h89ABCDEF);
  endtask

  task automatic test_sh_sb();
    issue(1'b1, 3'b001, 32'h06, 32'h00001234);
    checks++;
    if ({mem_write, mem_byteena, mem_addr, mem_wdata} !== {1'b1, 4'b1100, 10'd1, 32'h12341234}) begin
      errors++;
      $display("[TB] FAIL sh_req: got wr=%b be=%b a=%h d=%h expected 1 1100 001 12341234",
               mem_write, mem_byteena, mem_addr, mem_wdata);
    end
    repeat (WRITE_WAIT + 2) step();
    issue(1'b1, 3'b000, 32'h21, 32'h000000A5);
    checks++;
    if ({mem_write, mem_byteena, mem_addr, mem_wdata} !== {1'b1, 4'b0010, 10'd8, 32'hA5A5A5A5}) begin
      errors++;
      $display("[TB] FAIL sb_req: got wr=%b be=%b a=%h d=%h expected 1 0010 008 a5a5a5a5",
               mem_write, mem_byteena, mem_addr, mem_wdata);
    end
    repeat (WRITE_WAIT + 2) step();
  endtask

  task automatic test_lw_misaligned();
`ifdef MISALIGN_TRAP_EN
    logic [31:0] prev;
    prev = rdata_out;
    issue(1'b0, 3'b010, 32'h05, 32'h0);
    checks++;
    if ({done, misalign, mem_read, mem_write, busy} !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL lw_trap: got done/mis/rd/wr/busy=%b expected 11001",
               {done, misalign, mem_read, mem_write, busy});
    end
    step();
    checks++;
    if ({done, misalign, busy, mem_read, rdata_out} !== {4'b0000, prev}) begin
      errors++;
      $display("[TB] FAIL lw_trap_end: got %b data=%h expected 0000 %h",
               {done, misalign, busy, mem_read}, rdata_out, prev);
    end
`else
    run_load("lw_unaligned", 3'b010, 32'h05, 32'hCAFEF00D, 4'b1111, 10'd1, 32'hCAFEF00D);
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lw_no_trap: got misalign=%b expected 0", misalign);
    end
`endif
  endtask

  task automatic test_start_during_rd_wait();
    int done_count;
    done_count = 0;
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    step();
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata_in = 32'h1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, mem_read, mem_write, mem_addr} !== {3'b100, 10'd8}) begin
      errors++;
      $display("[TB] FAIL start_ignored: got busy/rd/wr=%b a=%h expected 100 008",
               {busy, mem_read, mem_write}, mem_addr);
    end
    mem_valid = 1'b1; mem_rdata = 32'h13579BDF;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) done_count++;
      step();
    end
    checks++;
    if ({done_count, rdata_out} !== {32'd1, 32'h13579BDF}) begin
      errors++;
      $display("[TB] FAIL single_done: got dones=%0d data=%h expected 1 13579bdf", done_count, rdata_out);
    end
  endtask

  task automatic test_reset_mid_rd_wait();
    int done_count;
    done_count = 0;
    issue(1'b0, 3'b010, 32'h30, 32'h0);
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({busy, mem_read, done, rdata_out} !== {3'b000, 32'd0}) begin
      errors++;
      $display("[TB] FAIL rst_mid: got busy/rd/done=%b data=%h expected 000 0",
               {busy, mem_read, done}, rdata_out);
    end
    rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_count++;
      step();
    end
    checks++;
    if ({done_count, rdata_out} !== {32'd0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL rst_no_done: got events=%0d data=%h expected 0 0", done_count, rdata_out);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb_lbu();
    test_sh_sb();
    test_lh_lhu();
    test_lw_misaligned();
    test_start_during_rd_wait();
    test_reset_mid_rd_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
